raw_stream_source: RTL and testbench
====================================

# raw_stream_source

Input-side streaming buffer that sits directly upstream of a generated app's raw-input port (e.g. `raw_oc_raw_update_0_read`). It accepts words from an external producer over a valid/ready handshake, stores them in a small FIFO, and presents the head word show-ahead to the app. The app consumes a word by pulsing its `read_en`. The block also reports occupancy, a running pop count, and an optional sticky underflow flag.

## Interface
- `WIDTH`, 16, data word width in bits.
- `DEPTH`, 8, FIFO depth in words; must be a power of two and at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear; has priority over push and pop.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_data`  in  WIDTH  producer word.
- `in_ready`  out  1  block can accept a word this cycle.
- `raw_oc_raw_update_0_read_en`  in  1  app consumes the head word this cycle.
- `raw_oc_raw_update_0_read`  out  WIDTH x [0:0]  head word, unpacked array of one lane.
- `raw_avail`  out  1  head word is valid (`level != 0`).
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `pop_count`  out  32  number of successful pops since reset or flush.
- `underflow`  out  1  sticky: the app read while the FIFO was empty.

## Operation
- **Storage:**
  - circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - `level` is tracked explicitly, from 0 to DEPTH.
- **Push:** occurs when `in_valid && in_ready`. `mem[wp] <= in_data`, then `wp++`.
- **`in_ready`:** equals `level < DEPTH`.
  - Depends on registered state only; a pop in the same cycle does not raise it (no full-bypass).
- **Pop:** occurs when `read_en && level != 0`. `rp++`, `pop_count++`.
  - `pop_count` wraps from 2^32-1 to 0.
- **Output:**
  - `raw_oc_raw_update_0_read[0] = (level != 0) ? mem[rp] : last`.
  - `last` is a register loaded with `mem[rp]` on every pop.
  - When the FIFO is empty, the output holds the most recently consumed word.
- **Simultaneous push and pop:** when `level` is between 1 and DEPTH-1, both occur and `level` is unchanged.
  - At `level == DEPTH` there is no push (`in_ready = 0`).
  - At `level == 0` there is no pop, because the pushed word is not yet visible (no empty-bypass).
- **Read while empty:** `read_en` with `level == 0` changes no pointer or count, and the output holds `last`. Underflow handling is described under Configuration.
- **Flush:** when `flush` is high at the clock edge:
  - clears `wp`, `rp`, `level`, `pop_count`, `last` and `underflow`;
  - any push or pop in that cycle is discarded;
  - the `mem` contents are don't-care.
- **Reset:** asynchronous assertion of `rst` forces the same state as flush, immediately. Any in-flight word is lost.

## Timing
- **Reset values:**
  - `in_ready` = 1;
  - `raw_avail` = 0;
  - `level` = 0;
  - `raw_oc_raw_update_0_read[0]` = 0;
  - `pop_count` = 0;
  - `underflow` = 0.
- **Push latency:** a word pushed at edge N is visible on the output, with `raw_avail` = 1, from just after edge N.
  - It can be popped at edge N+1 at the earliest.
- **Pop latency:** a pop at edge N presents the next word (or `last`) just after edge N. One word per cycle is sustained.
- **Throughput:** with a continuous producer and consumer, the FIFO reaches steady state at one word per cycle with no bubbles.
- **Registered outputs:** `level` and `pop_count` are registered.
- **Combinational outputs:** `in_ready`, `raw_avail` and the data output are combinational from registered state only. No input-to-output combinational path exists.

## Configuration
- **Macro:** `RAW_STREAM_SOURCE_UNDERFLOW_CHECK_EN`.
- **Defined:**
  - `underflow` sets on any edge where `read_en && level == 0 && !flush`;
  - it stays set until `rst` or `flush`;
  - the simulation also emits `$error` once per offending cycle.
- **Undefined:** `underflow` is tied to 0, and no check logic or message is generated. All other behaviour is identical.

## Test plan
- **Reset then idle:** assert `rst` mid-cycle -> all outputs take their reset values immediately; `in_ready` = 1 and `raw_avail` = 0 after release.
- **Fill to full:** push 1..8 with `read_en` = 0 -> `level` = 8, `in_ready` = 0, output = 1; a 9th `in_valid` is not accepted.
- **Drain in order:**
  - from full, hold `read_en` = 1 for 8 cycles -> output sequence 1..8, `pop_count` = 8, `level` = 0;
  - afterwards the output holds 8.
- **Streaming:**
  - push an incrementing counter every cycle with `read_en` = 1 continuously, for 100 cycles;
  - pointers wrap more than 10 times;
  - required response: consumed values are gap-free and in order, and `level` never exceeds 1.
- **Underflow (macro defined):**
  - `read_en` = 1 while empty, with a simultaneous push of 0x0ABC -> `underflow` = 1, `pop_count` unchanged, `level` = 1, output = 0x0ABC;
  - the flag persists until `flush`.
- **Flush mid-operation:** at `level` = 5, assert `flush` together with a push and a pop -> next cycle `level` = 0, `pop_count` = 0, output = 0, `underflow` = 0.

Source files
------------

// File: rtl/raw_stream_source.sv
// raw_stream_source
// Input-side streaming buffer for a generated app's raw-input port. A producer
// pushes words over a valid/ready handshake into a small circular FIFO. The
// head word is presented show-ahead to the app, which consumes it by pulsing
// raw_oc_raw_update_0_read_en.
//
// Optional feature: define RAW_STREAM_SOURCE_UNDERFLOW_CHECK_EN to enable the
// sticky underflow flag and its simulation message. Without the macro,
// underflow is tied low.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   flush                          synchronous clear (beats push and pop)
//   in_valid, in_data, in_ready    producer handshake
//   raw_oc_raw_update_0_read_en    app consumes the head word
//   raw_oc_raw_update_0_read[0]    head word, or the last consumed word when empty
//   raw_avail                      head word is valid
//   level                          occupancy, 0..DEPTH
//   pop_count                      successful pops since reset/flush (wraps)
//   underflow                      sticky read-while-empty flag
module raw_stream_source #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     raw_oc_raw_update_0_read_en,
  output logic [WIDTH-1:0]         raw_oc_raw_update_0_read [0:0],
  output logic                     raw_avail,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              pop_count,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [WIDTH-1:0] last;
  logic             push;
  logic             pop;
  logic             empty;

  // Handshake and pop qualification look only at registered state, so there
  // is no combinational path from any input to any output.
  assign empty     = (level == '0);
  assign in_ready  = (level < LW'(DEPTH));
  assign raw_avail = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = raw_oc_raw_update_0_read_en && !empty;

  // Show-ahead head word; when drained, hold the most recently consumed word.
  always_comb begin
    raw_oc_raw_update_0_read[0] = empty ? last : mem[rp];
  end

  // Control state: pointers, occupancy, pop counter and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      pop_count <= '0;
      last      <= '0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      pop_count <= '0;
      last      <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp        <= rp + 1'b1;
        pop_count <= pop_count + 32'd1;
        last      <= mem[rp];
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array carries no reset; its contents are don't-care after a clear.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= in_data;
    end
  end

`ifdef RAW_STREAM_SOURCE_UNDERFLOW_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (flush) begin
      underflow <= 1'b0;
    end else if (raw_oc_raw_update_0_read_en && empty) begin
      underflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !flush && raw_oc_raw_update_0_read_en && empty) begin
      $error("raw_stream_source: read while empty");
    end
  end
`endif
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_raw_stream_source.sv
module tb_raw_stream_source;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef RAW_STREAM_SOURCE_UNDERFLOW_CHECK_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             read_en;
  logic [WIDTH-1:0] rd [0:0];
  logic             raw_avail;
  logic [3:0]       level;
  logic [31:0]      pop_count;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of stored words plus the visible scalars.
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_last;
  int unsigned      m_pc;
  bit               m_uf;

  raw_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .flush                       (flush),
    .in_valid                    (in_valid),
    .in_data                     (in_data),
    .in_ready                    (in_ready),
    .raw_oc_raw_update_0_read_en (read_en),
    .raw_oc_raw_update_0_read    (rd),
    .raw_avail                   (raw_avail),
    .level                       (level),
    .pop_count                   (pop_count),
    .underflow                   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_last = '0;
    m_pc   = 0;
    m_uf   = 1'b0;
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : m_last;
    check_eq("level",     32'(level),     32'(q.size()));
    check_eq("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    check_eq("raw_avail", 32'(raw_avail), 32'(q.size() != 0));
    check_eq("data",      32'(rd[0]),     32'(exp_data));
    check_eq("pop_count", pop_count,      m_pc);
    check_eq("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit re, input bit fl);
    bit ready, was_empty;
    in_valid = v;
    in_data  = d;
    read_en  = re;
    flush    = fl;
    ready     = (q.size() < DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (re && !was_empty) begin
        m_last = q.pop_front();
        m_pc   = m_pc + 1;
      end
      if (v && ready) q.push_back(d);
      if (re && was_empty && UF_EN) m_uf = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; read_en = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Fill to full, then offer a ninth word that must be refused.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_eq("full_level", 32'(level), 32'd8);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    check_eq("full_head", 32'(rd[0]), 32'd1);
    cycle(1'b1, 16'd9, 1'b0, 1'b0);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("drain_pc", pop_count, 32'd8);
    check_eq("drain_hold", 32'(rd[0]), 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Streaming: counter pushed every cycle, consumer always reading.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, WIDTH'(16'h100 + i), (i > 0), 1'b0);
      check_eq("stream_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("stream_pc", pop_count, 32'd100);
    check_eq("stream_last", 32'(rd[0]), 32'h163);

    // Read while empty with a simultaneous push.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0ABC, 1'b1, 1'b0);
    check_eq("uf_flag", 32'(underflow), 32'(UF_EN));
    check_eq("uf_head", 32'(rd[0]), 32'h0ABC);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("uf_sticky", 32'(underflow), 32'(UF_EN));

    // Flush at level 5 together with push and pop.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(16'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h77, 1'b1, 1'b1);
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_data", 32'(rd[0]), 32'd0);

    // Randomized traffic; avoid reads on empty when the check would fire.
    for (int i = 0; i < 400; i++) begin
      bit v, re, fl;
      v  = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 60) == 0);
      if (UF_EN && q.size() == 0) re = 1'b0;
      cycle(v, WIDTH'($urandom), re, fl);
    end

    // Asynchronous reset asserted mid-cycle with data in the FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
